// File: rtl/imem_boot_pkg.sv
// -----------------------------------------------------------------------------
// imem_boot_pkg
// Shared types and helpers for the instruction-memory boot sequencer.
//   boot_state_t : sequencer FSM states
//   boot_mode_t  : load source (word stream or generated IRMOV seed)
//   IRMOV_OP     : opcode byte placed in the top byte of a seed word
//   irmov_enc()  : builds the 32-bit IRMOV word {op, reg, imm16}
// No ports; imported by imem_boot_timer and imem_boot_seq.
// -----------------------------------------------------------------------------
package imem_boot_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } boot_state_t;

    typedef enum logic {
        MODE_STREAM = 1'b0,
        MODE_SEED   = 1'b1
    } boot_mode_t;

    localparam logic [7:0] IRMOV_OP = 8'h10;

    function automatic logic [31:0] irmov_enc(input logic [7:0]  reg_idx,
                                              input logic [15:0] imm16);
        return {IRMOV_OP, reg_idx, imm16};
    endfunction

endpackage

// File: rtl/imem_boot_timer.sv
// -----------------------------------------------------------------------------
// imem_boot_timer
// Loadable down-counter that measures the RUN phase of the boot sequencer.
// Ports:
//   clock  in  : rising-edge clock
//   reset  in  : synchronous active-high reset
//   load   in  : reload the counter with RUN_CYCLES
//   en     in  : high while the sequencer is in RUN
//   expire out : combinational pulse in the last enabled cycle of the run
// RUN_CYCLES = 0 selects an endless run: expire never fires.
// -----------------------------------------------------------------------------
module imem_boot_timer
    import imem_boot_pkg::*;
#(
    parameter int unsigned RUN_CYCLES = 10
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam int unsigned CNT_W = (RUN_CYCLES < 2) ? 1 : $clog2(RUN_CYCLES + 1);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(RUN_CYCLES);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Count value 1 marks the final cycle; the loaded value itself counts as
    // the first RUN cycle, so RUN lasts exactly RUN_CYCLES cycles.
    assign expire = (RUN_CYCLES != 0) && en && (cnt_q == ONE);

endmodule

// File: rtl/imem_boot_seq.sv
// -----------------------------------------------------------------------------
// imem_boot_seq
// Boot sequencer in front of the processor's instruction-memory write port.
// Fills imem from a valid/ready stream or from generated IRMOV seed words,
// then raises `working` for RUN_CYCLES cycles (0 = until abort), then pulses
// `done` and returns to IDLE.
// Ports:
//   clock, reset              : clock, synchronous active-high reset
//   start, mode, base,        : sequence request; mode/base/load_count are
//   load_count                  latched when start is taken in IDLE
//   abort                     : return to IDLE from any state
//   in_valid/in_data/in_ready : stream input handshake (in_ready is a
//                               combinational decode, all else registered)
//   addr/wEn/wDat             : imem write port
//   working                   : processor enable
//   busy                      : high while in LOAD or RUN
//   done                      : one-cycle pulse after RUN
//   loaded_count              : words written in the current/last sequence
//   checksum                  : (IMEM_BOOT_CHECKSUM_EN only) running XOR of
//                               the words written in the current sequence
// Optional feature macro: IMEM_BOOT_CHECKSUM_EN.
// -----------------------------------------------------------------------------
module imem_boot_seq
    import imem_boot_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 9,
    parameter int unsigned NUM_REGS   = 4,
    parameter int unsigned RUN_CYCLES = 10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [15:0]       base,
    input  logic [ADDR_W:0]   load_count,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] addr,
    output logic              wEn,
    output logic [DATA_W-1:0] wDat,
    output logic              working,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   loaded_count
`ifdef IMEM_BOOT_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    localparam int unsigned    CNT_W      = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] MAX_WORDS  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [CNT_W-1:0] SEED_WORDS = CNT_W'(NUM_REGS);

    boot_state_t       state_q, state_d;
    boot_mode_t        mode_q, mode_d;
    logic [15:0]       base_q, base_d;
    logic [CNT_W-1:0]  lc_q, lc_d;
    logic [CNT_W-1:0]  acc_cnt_q, acc_cnt_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic              pend_vld_q, pend_vld_d;
    logic [DATA_W-1:0] pend_dat_q, pend_dat_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wen_q, wen_d;
    logic [DATA_W-1:0] wdat_q, wdat_d;
    logic              working_q, working_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
`ifdef IMEM_BOOT_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d;
`endif

    logic accept;
    logic timer_load;
    logic timer_en;
    logic timer_expire;

    // Stream words are accepted while fewer than load_count have been taken;
    // the accept counter runs one word ahead of the write counter.
    assign in_ready = (state_q == ST_LOAD) && (mode_q == MODE_STREAM) &&
                      (acc_cnt_q < lc_q);
    assign accept   = in_ready && in_valid;

    assign timer_load = (state_d == ST_RUN) && (state_q != ST_RUN);
    assign timer_en   = (state_q == ST_RUN);

    imem_boot_timer #(
        .RUN_CYCLES (RUN_CYCLES)
    ) u_timer (
        .clock  (clock),
        .reset  (reset),
        .load   (timer_load),
        .en     (timer_en),
        .expire (timer_expire)
    );

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        base_d     = base_q;
        lc_d       = lc_q;
        acc_cnt_d  = acc_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        pend_vld_d = 1'b0;
        pend_dat_d = pend_dat_q;
        addr_d     = addr_q;
        wen_d      = 1'b0;
        wdat_d     = wdat_q;
        working_d  = 1'b0;
        done_d     = 1'b0;
`ifdef IMEM_BOOT_CHECKSUM_EN
        csum_d     = csum_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d   = ST_LOAD;
                    mode_d    = boot_mode_t'(mode);
                    base_d    = base;
                    lc_d      = (load_count > MAX_WORDS) ? MAX_WORDS : load_count;
                    acc_cnt_d = '0;
                    wr_cnt_d  = '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
                    csum_d    = '0;
`endif
                end
            end

            ST_LOAD: begin
                if (mode_q == MODE_SEED) begin
                    wen_d    = 1'b1;
                    addr_d   = wr_cnt_q[ADDR_W-1:0];
                    wdat_d   = DATA_W'(irmov_enc(8'(wr_cnt_q),
                                                 base_q + 16'(wr_cnt_q)));
                    wr_cnt_d = wr_cnt_q + CNT_ONE;
                    if (wr_cnt_d == SEED_WORDS) begin
                        state_d = ST_RUN;
                    end
                end else begin
                    // Word accepted last cycle is written now, in order.
                    if (pend_vld_q) begin
                        wen_d    = 1'b1;
                        addr_d   = wr_cnt_q[ADDR_W-1:0];
                        wdat_d   = pend_dat_q;
                        wr_cnt_d = wr_cnt_q + CNT_ONE;
                    end
                    if (accept) begin
                        pend_vld_d = 1'b1;
                        pend_dat_d = in_data;
                        acc_cnt_d  = acc_cnt_q + CNT_ONE;
                    end
                    // Also covers load_count = 0: nothing to write, go to RUN.
                    if (wr_cnt_d == lc_q) begin
                        state_d = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                working_d = 1'b1;
                if (timer_expire) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort) begin
            state_d    = ST_IDLE;
            wen_d      = 1'b0;
            working_d  = 1'b0;
            done_d     = 1'b0;
            pend_vld_d = 1'b0;
        end

`ifdef IMEM_BOOT_CHECKSUM_EN
        if (wen_d) begin
            csum_d = csum_d ^ wdat_d;
        end
`endif

        busy_d = (state_d == ST_LOAD) || (state_d == ST_RUN);
    end

    // Control and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_STREAM;
            lc_q       <= '0;
            acc_cnt_q  <= '0;
            wr_cnt_q   <= '0;
            pend_vld_q <= 1'b0;
            addr_q     <= '0;
            wen_q      <= 1'b0;
            wdat_q     <= '0;
            working_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef IMEM_BOOT_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            lc_q       <= lc_d;
            acc_cnt_q  <= acc_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            pend_vld_q <= pend_vld_d;
            addr_q     <= addr_d;
            wen_q      <= wen_d;
            wdat_q     <= wdat_d;
            working_q  <= working_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef IMEM_BOOT_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    // Datapath holding registers; only meaningful under their valid/state
    always_ff @(posedge clock) begin
        base_q     <= base_d;
        pend_dat_q <= pend_dat_d;
    end

    assign addr         = addr_q;
    assign wEn          = wen_q;
    assign wDat         = wdat_q;
    assign working      = working_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign loaded_count = wr_cnt_q;
`ifdef IMEM_BOOT_CHECKSUM_EN
    assign checksum     = csum_q;
`endif

endmodule

// File: tb/tb_imem_boot_seq.sv
module tb_imem_boot_seq;

    logic        clock;
    logic        reset;
    logic        start1, start2;
    logic        mode;
    logic [15:0] base;
    logic [9:0]  load_count;
    logic        abort;
    logic        in_valid;
    logic [31:0] in_data;

    logic        in_ready, wEn, working, busy, done;
    logic [8:0]  addr;
    logic [31:0] wDat;
    logic [9:0]  loaded_count;

    logic        in_ready2, wEn2, working2, busy2, done2;
    logic [8:0]  addr2;
    logic [31:0] wDat2;
    logic [9:0]  loaded_count2;
`ifdef IMEM_BOOT_CHECKSUM_EN
    logic [31:0] checksum, checksum2;
`endif

    int checks   = 0;
    int failures = 0;

    imem_boot_seq #(.DATA_W(32), .ADDR_W(9), .NUM_REGS(4), .RUN_CYCLES(10)) dut1 (
        .clock(clock), .reset(reset), .start(start1), .mode(mode), .base(base),
        .load_count(load_count), .abort(abort), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .addr(addr), .wEn(wEn),
        .wDat(wDat), .working(working), .busy(busy), .done(done),
        .loaded_count(loaded_count)
`ifdef IMEM_BOOT_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    imem_boot_seq #(.DATA_W(32), .ADDR_W(9), .NUM_REGS(2), .RUN_CYCLES(3)) dut2 (
        .clock(clock), .reset(reset), .start(start2), .mode(mode), .base(base),
        .load_count(load_count), .abort(abort), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready2), .addr(addr2), .wEn(wEn2),
        .wDat(wDat2), .working(working2), .busy(busy2), .done(done2),
        .loaded_count(loaded_count2)
`ifdef IMEM_BOOT_CHECKSUM_EN
        , .checksum(checksum2)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        checks++;
        if ({addr, wEn, wDat, working, busy, done, loaded_count, in_ready} !== '0) begin
            failures++;
            $display("FAIL reset_dut1 got addr=%0h wEn=%0b wDat=%0h working=%0b busy=%0b done=%0b lc=%0d ready=%0b exp all 0",
                     addr, wEn, wDat, working, busy, done, loaded_count, in_ready);
        end
        checks++;
        if ({addr2, wEn2, wDat2, working2, busy2, done2, loaded_count2} !== '0) begin
            failures++;
            $display("FAIL reset_dut2 got addr=%0h wEn=%0b wDat=%0h working=%0b exp all 0",
                     addr2, wEn2, wDat2, working2);
        end
`ifdef IMEM_BOOT_CHECKSUM_EN
        checks++;
        if (checksum !== 32'h0) begin
            failures++;
            $display("FAIL reset_checksum got=%0h exp=0", checksum);
        end
`endif
    endtask

    task automatic test_seed();
        logic [31:0] exp_w [4];
        int wcyc, dcnt, overlap, wen_late;
        logic prev_working;
        exp_w[0] = 32'h1000001c; exp_w[1] = 32'h1001001d;
        exp_w[2] = 32'h1002001e; exp_w[3] = 32'h1003001f;
        mode = 1'b1; base = 16'd28; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        checks++;
        if (wEn !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL seed_first_cycle got wEn=%0b busy=%0b exp wEn=0 busy=1", wEn, busy);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (wEn !== 1'b1 || addr !== 9'(i) || wDat !== exp_w[i] || working !== 1'b0) begin
                failures++;
                $display("FAIL seed_write%0d got wEn=%0b addr=%0d wDat=%0h working=%0b exp wEn=1 addr=%0d wDat=%0h working=0",
                         i, wEn, addr, wDat, working, i, exp_w[i]);
            end
`ifdef IMEM_BOOT_CHECKSUM_EN
            if (i == 0) begin
                checks++;
                if (checksum !== 32'h1000001c) begin
                    failures++;
                    $display("FAIL seed_checksum_first got=%0h exp=1000001c", checksum);
                end
            end
`endif
        end
        tick();
        checks++;
        if (wEn !== 1'b0 || working !== 1'b1 || loaded_count !== 10'd4) begin
            failures++;
            $display("FAIL seed_run_entry got wEn=%0b working=%0b lc=%0d exp wEn=0 working=1 lc=4",
                     wEn, working, loaded_count);
        end
        wcyc = 1; dcnt = 0; overlap = 0; wen_late = 0; prev_working = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (c == 2) begin mode = 1'b0; load_count = 10'd5; start1 = 1'b1; end
            if (c == 3) start1 = 1'b0;
            tick();
            if (working) wcyc++;
            if (wEn) wen_late++;
            if (wEn && working) overlap++;
            if (done) begin
                dcnt++;
                checks++;
                if (prev_working !== 1'b1 || working !== 1'b0) begin
                    failures++;
                    $display("FAIL seed_done_timing got prev_working=%0b working=%0b exp 1,0",
                             prev_working, working);
                end
            end
            prev_working = working;
        end
        checks++;
        if (wcyc != 10) begin
            failures++;
            $display("FAIL seed_run_len got=%0d exp=10", wcyc);
        end
        checks++;
        if (dcnt != 1 || overlap != 0 || wen_late != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL seed_tail got done=%0d overlap=%0d late_wEn=%0d busy=%0b exp 1,0,0,0",
                     dcnt, overlap, wen_late, busy);
        end
`ifdef IMEM_BOOT_CHECKSUM_EN
        checks++;
        if (checksum !== 32'h00000000) begin
            failures++;
            $display("FAIL seed_checksum got=%0h exp=0", checksum);
        end
`endif
    endtask

    task automatic test_stream();
        int found;
        mode = 1'b0; load_count = 10'd3; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || wEn !== 1'b0) begin
            failures++;
            $display("FAIL stream_ready got ready=%0b wEn=%0b exp 1,0", in_ready, wEn);
        end
        in_valid = 1'b1; in_data = 32'hA5A50000;
        tick();
        checks++;
        if (wEn !== 1'b0) begin
            failures++;
            $display("FAIL stream_latency got wEn=%0b exp=0", wEn);
        end
        in_data = 32'hA5A50001;
        tick();
        checks++;
        if (wEn !== 1'b1 || addr !== 9'd0 || wDat !== 32'hA5A50000) begin
            failures++;
            $display("FAIL stream_w0 got wEn=%0b addr=%0d wDat=%0h exp 1,0,a5a50000", wEn, addr, wDat);
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (wEn !== 1'b1 || addr !== 9'd1 || wDat !== 32'hA5A50001 || loaded_count !== 10'd2) begin
            failures++;
            $display("FAIL stream_w1 got wEn=%0b addr=%0d wDat=%0h lc=%0d exp 1,1,a5a50001,2",
                     wEn, addr, wDat, loaded_count);
        end
        tick();
        checks++;
        if (wEn !== 1'b0 || addr !== 9'd1) begin
            failures++;
            $display("FAIL stream_gap1 got wEn=%0b addr=%0d exp 0,1", wEn, addr);
        end
        in_valid = 1'b1; in_data = 32'h5A5A0002;
        tick();
        checks++;
        if (wEn !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL stream_gap2 got wEn=%0b ready=%0b exp 0,0", wEn, in_ready);
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (wEn !== 1'b1 || addr !== 9'd2 || wDat !== 32'h5A5A0002 || loaded_count !== 10'd3) begin
            failures++;
            $display("FAIL stream_w2 got wEn=%0b addr=%0d wDat=%0h lc=%0d exp 1,2,5a5a0002,3",
                     wEn, addr, wDat, loaded_count);
        end
        tick();
        checks++;
        if (working !== 1'b1 || wEn !== 1'b0) begin
            failures++;
            $display("FAIL stream_run got working=%0b wEn=%0b exp 1,0", working, wEn);
        end
        found = 0;
        for (int c = 0; c < 20 && found == 0; c++) begin
            tick();
            if (done) found = 1;
        end
        checks++;
        if (found != 1) begin
            failures++;
            $display("FAIL stream_done got=timeout exp=done pulse");
        end
        tick();
    endtask

    task automatic test_seed_wrap();
        int wcyc, found;
        mode = 1'b1; base = 16'hFFFF; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        tick();
        checks++;
        if (wEn2 !== 1'b1 || addr2 !== 9'd0 || wDat2 !== 32'h1000FFFF) begin
            failures++;
            $display("FAIL wrap_w0 got wEn=%0b addr=%0d wDat=%0h exp 1,0,1000ffff", wEn2, addr2, wDat2);
        end
        tick();
        checks++;
        if (wEn2 !== 1'b1 || addr2 !== 9'd1 || wDat2 !== 32'h10010000) begin
            failures++;
            $display("FAIL wrap_w1 got wEn=%0b addr=%0d wDat=%0h exp 1,1,10010000", wEn2, addr2, wDat2);
        end
`ifdef IMEM_BOOT_CHECKSUM_EN
        checks++;
        if (checksum2 !== 32'h0001FFFF) begin
            failures++;
            $display("FAIL wrap_checksum got=%0h exp=0001ffff", checksum2);
        end
`endif
        wcyc = 0; found = 0;
        for (int c = 0; c < 12 && found == 0; c++) begin
            tick();
            if (working2) wcyc++;
            if (done2) found = 1;
        end
        checks++;
        if (wcyc != 3 || found != 1) begin
            failures++;
            $display("FAIL wrap_run got working_cycles=%0d done=%0d exp 3,1", wcyc, found);
        end
        tick();
    endtask

    task automatic test_abort();
        int found, bad;
        mode = 1'b1; base = 16'd0; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        found = 0;
        for (int c = 0; c < 20 && found == 0; c++) begin
            tick();
            if (working) found = 1;
        end
        checks++;
        if (found != 1) begin
            failures++;
            $display("FAIL abort_wait_run got=timeout exp=working");
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (working !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || wEn !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle got working=%0b busy=%0b done=%0b wEn=%0b ready=%0b exp all 0",
                     working, busy, done, wEn, in_ready);
        end
        bad = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (done || working || busy) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL abort_quiet got active_cycles=%0d exp=0", bad);
        end
        base = 16'd5; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick();
        checks++;
        if (wEn !== 1'b1 || addr !== 9'd0 || wDat !== 32'h10000005) begin
            failures++;
            $display("FAIL abort_restart got wEn=%0b addr=%0d wDat=%0h exp 1,0,10000005", wEn, addr, wDat);
        end
        found = 0;
        for (int c = 0; c < 30 && found == 0; c++) begin
            tick();
            if (done) found = 1;
        end
        checks++;
        if (found != 1) begin
            failures++;
            $display("FAIL abort_restart_done got=timeout exp=done pulse");
        end
        tick();
    endtask

    task automatic test_stream_zero();
        mode = 1'b0; load_count = 10'd0; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || wEn !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL zero_load got ready=%0b wEn=%0b busy=%0b exp 0,0,1", in_ready, wEn, busy);
        end
        tick();
        checks++;
        if (working !== 1'b0 || wEn !== 1'b0) begin
            failures++;
            $display("FAIL zero_run_state got working=%0b wEn=%0b exp 0,0", working, wEn);
        end
        tick();
        checks++;
        if (working !== 1'b1 || wEn !== 1'b0 || loaded_count !== 10'd0) begin
            failures++;
            $display("FAIL zero_working got working=%0b wEn=%0b lc=%0d exp 1,0,0", working, wEn, loaded_count);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (working !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL zero_abort got working=%0b done=%0b exp 0,0", working, done);
        end
    endtask

    task automatic test_start_abort_idle();
        mode = 1'b1; start1 = 1'b1; abort = 1'b1;
        tick();
        start1 = 1'b0; abort = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || wEn !== 1'b0) begin
            failures++;
            $display("FAIL start_abort_idle got busy=%0b wEn=%0b exp 0,0", busy, wEn);
        end
    endtask

    task automatic test_reset_mid();
        mode = 1'b1; base = 16'd100; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick();
        tick();
        checks++;
        if (loaded_count !== 10'd2 || wEn !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_pre got lc=%0d wEn=%0b exp 2,1", loaded_count, wEn);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (loaded_count !== 10'd0 || wEn !== 1'b0 || busy !== 1'b0 || addr !== 9'd0 || wDat !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid got lc=%0d wEn=%0b busy=%0b addr=%0d wDat=%0h exp all 0",
                     loaded_count, wEn, busy, addr, wDat);
        end
        tick();
        checks++;
        if (wEn !== 1'b0 || working !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_after got wEn=%0b working=%0b busy=%0b exp 0,0,0", wEn, working, busy);
        end
    endtask

    initial begin
        reset = 1'b1; start1 = 1'b0; start2 = 1'b0; mode = 1'b0; base = 16'd0;
        load_count = 10'd0; abort = 1'b0; in_valid = 1'b0; in_data = 32'h0;
        test_reset();
        test_seed();
        test_stream();
        test_seed_wrap();
        test_abort();
        test_stream_zero();
        test_start_abort_idle();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
